uart_mem_loader: RTL and testbench

Hardware memory initiator that turns a UART byte stream into memory-bus transactions. Hosts use it to load or dump main memory and boot memory without CPU involvement. It drives the same mem_* initiator interface the pipeline drives; the top level muxes it onto the bus and holds the pipeline in reset while busy is high. Received bytes come from a UART receiver, and replies go to a UART transmitter.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/loader_timeout.sv | 34 +++
 rtl/uart_mem_loader.sv | 145 ++++++++++++++
 tb/tb_uart_mem_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and command constants for the UART memory loader.
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    WDATA = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSEND = 3'd5,
    ACK   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam int         HDR_BYTES = 6;

endpackage

`default_nettype wire

// File: rtl/loader_timeout.sv
// loader_timeout: inter-byte watchdog; expired asserts after TIMEOUT_CYCLES enabled cycles without a clear.
`default_nettype none

module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  // Saturates at LIMIT so expired stays asserted until the FSM leaves the timed states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: turns a UART command stream into byte-granular memory reads/writes with tx replies.
`default_nettype none

module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_200_000,
  parameter logic [7:0] ACK_BYTE       = 8'h06
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_t      state, next_state;
  logic [31:0] addr;
  logic [15:0] remaining;
  logic [2:0]  hdr_cnt;
  logic        is_write;
  logic [7:0]  rbyte;
  logic        timed;
  logic        expired;

  assign timed = (state == HDR) || (state == WDATA);

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid || !timed),
    .enable  (timed),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    mem_wmask  = 4'b0000;
    mem_wdata  = 32'h0;
    mem_addr   = addr;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) next_state = HDR;
      end
      HDR: begin
        if (expired) begin
          next_state = IDLE;
        end else if (rx_valid && hdr_cnt == 3'(HDR_BYTES - 1)) begin
          // The final header byte is the length MSB, so test the length before it is registered.
          if ({rx_data, remaining[15:8]} == 16'd0) next_state = ACK;
          else if (is_write)                       next_state = WDATA;
          else                                     next_state = RADDR;
        end
      end
      WDATA: begin
        if (expired) begin
          next_state = IDLE;
        end else if (rx_valid) begin
          mem_valid = 1'b1;
          mem_write = 1'b1;
          mem_wmask = 4'b0001 << addr[1:0];
          mem_wdata = {4{rx_data}};
          if (remaining == 16'd1) next_state = ACK;
        end
      end
      RADDR: begin
        mem_valid  = 1'b1;
        next_state = RDATA;
      end
      RDATA: next_state = RSEND;
      RSEND: begin
        tx_valid = 1'b1;
        tx_data  = rbyte;
        if (tx_ready) next_state = (remaining == 16'd1) ? ACK : RADDR;
      end
      ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= 32'h0;
      remaining <= 16'h0;
      hdr_cnt   <= 3'd0;
      is_write  <= 1'b0;
      rbyte     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          hdr_cnt  <= 3'd0;
          is_write <= (rx_data == CMD_WRITE);
        end
        HDR: begin
          if (rx_valid && !expired) begin
            hdr_cnt <= hdr_cnt + 3'd1;
            if (hdr_cnt < 3'd4) addr      <= {rx_data, addr[31:8]};
            else                remaining <= {rx_data, remaining[15:8]};
          end
        end
        WDATA: begin
          if (rx_valid && !expired) begin
            addr      <= addr + 32'd1;
            remaining <= remaining - 16'd1;
          end
        end
        RDATA: rbyte <= mem_rdata[{addr[1:0], 3'b000} +: 8];
        RSEND: begin
          if (tx_ready) begin
            addr      <= addr + 32'd1;
            remaining <= remaining - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: scenario tasks against a byte-level reference model of the loader protocol.
`default_nettype none

module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        mem_valid, mem_write, busy;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  uart_mem_loader #(.TIMEOUT_CYCLES(100), .ACK_BYTE(8'h06)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } op_t;

  op_t        got_ops[$], exp_ops[$];
  logic [7:0] got_tx[$],  exp_tx[$];
  logic [31:0] mem_words [logic [29:0]];
  logic [7:0]  ref_mem   [logic [31:0]];
  int checks = 0, passes = 0;
  bit rand_ready = 0;

  // Word-wide synchronous memory driven by the DUT.
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) begin : wr
        logic [31:0] w;
        w = mem_words.exists(mem_addr[31:2]) ? mem_words[mem_addr[31:2]] : 32'h0;
        for (int i = 0; i < 4; i++) if (mem_wmask[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        mem_words[mem_addr[31:2]] = w;
      end else begin
        mem_rdata <= mem_words.exists(mem_addr[31:2]) ? mem_words[mem_addr[31:2]] : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid) got_ops.push_back({mem_write, mem_addr, mem_wmask, mem_write ? mem_wdata : 32'h0});
      if (tx_valid && tx_ready) got_tx.push_back(tx_data);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_queues();
    got_ops.delete(); exp_ops.delete(); got_tx.delete(); exp_tx.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0; rx_data = 8'h00;
    step($urandom_range(0, 2));
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input int len, input logic [7:0] data[$]);
    logic [15:0] l;
    l = 16'(len);
    send_byte(cmd);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
    if (cmd == 8'h57) for (int i = 0; i < len; i++) send_byte(data[i]);
  endtask

  // Reference: each byte of a frame is one access at a+i (wrapping); reads return the last byte written there.
  task automatic model_frame(input logic [7:0] cmd, input logic [31:0] a, input int len, input logic [7:0] data[$]);
    logic [31:0] ai;
    logic [3:0]  m;
    for (int i = 0; i < len; i++) begin
      ai = a + 32'(i);
      m  = 4'b0001 << ai[1:0];
      if (cmd == 8'h57) begin
        exp_ops.push_back({1'b1, ai, m, {4{data[i]}}});
        ref_mem[ai] = data[i];
      end else begin
        exp_ops.push_back({1'b0, ai, 4'b0000, 32'h0});
        exp_tx.push_back(ref_mem.exists(ai) ? ref_mem[ai] : 8'h00);
      end
    end
    exp_tx.push_back(8'h06);
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    while (busy && n < budget) begin step(1); n++; end
    timed_out = busy;
    step(1);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr, tx_valid, tx_data} !== '0)
      $display("FAIL reset_outputs: got busy=%b mv=%b tv=%b addr=%h wdata=%h tx=%h, need all 0",
               busy, mem_valid, tx_valid, mem_addr, mem_wdata, tx_data);
    else passes++;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_write_aligned();
    logic [7:0] d[$];
    bit to;
    clear_queues();
    d = {8'h11, 8'h22, 8'h33, 8'h44};
    model_frame(8'h57, 32'h0002_0000, 4, d);
    send_frame(8'h57, 32'h0002_0000, 4, d);
    wait_idle(50, to);
    checks++; if (to) $display("FAIL write_aligned_idle: busy still 1, need 0"); else passes++;
    checks++;
    if (got_ops.size() != exp_ops.size()) $display("FAIL write_aligned_count: got %0d ops, need %0d", got_ops.size(), exp_ops.size());
    else passes++;
    for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++) begin
      checks++;
      if (got_ops[i] !== exp_ops[i]) $display("FAIL write_aligned_op%0d: got %h, need %h", i, got_ops[i], exp_ops[i]);
      else passes++;
    end
    checks++;
    if (got_tx.size() != 1 || got_tx[0] !== exp_tx[0]) $display("FAIL write_aligned_ack: got %0d bytes (first %h), need 1 byte %h", got_tx.size(), got_tx.size() ? got_tx[0] : 8'hxx, exp_tx[0]);
    else passes++;
  endtask

  task automatic test_read_unaligned();
    logic [7:0] d[$];
    bit to;
    clear_queues();
    mem_words[30'd1] = 32'hAABB_CCDD;
    ref_mem[32'd4] = 8'hDD; ref_mem[32'd5] = 8'hCC; ref_mem[32'd6] = 8'hBB; ref_mem[32'd7] = 8'hAA;
    model_frame(8'h52, 32'd5, 2, d);
    send_frame(8'h52, 32'd5, 2, d);
    wait_idle(50, to);
    checks++; if (to) $display("FAIL read_unaligned_idle: busy still 1, need 0"); else passes++;
    checks++;
    if (got_ops.size() != exp_ops.size()) $display("FAIL read_unaligned_count: got %0d ops, need %0d", got_ops.size(), exp_ops.size());
    else passes++;
    for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++) begin
      checks++;
      if (got_ops[i] !== exp_ops[i]) $display("FAIL read_unaligned_op%0d: got %h, need %h", i, got_ops[i], exp_ops[i]);
      else passes++;
    end
    checks++;
    if (got_tx != exp_tx) $display("FAIL read_unaligned_tx: got %p, need %p", got_tx, exp_tx);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] d[$];
    bit to, stable;
    int n;
    clear_queues();
    tx_ready = 1'b0;
    model_frame(8'h52, 32'd5, 2, d);
    send_frame(8'h52, 32'd5, 2, d);
    n = 0;
    while (!tx_valid && n < 20) begin step(1); n++; end
    stable = tx_valid;
    for (int c = 0; c < 50; c++) begin
      if (!tx_valid || tx_data !== exp_tx[0]) stable = 0;
      step(1);
    end
    checks++;
    if (!stable) $display("FAIL backpressure_hold: tx_valid=%b tx_data=%h, need 1 and %h held", tx_valid, tx_data, exp_tx[0]);
    else passes++;
    checks++;
    if (got_ops.size() != 1) $display("FAIL backpressure_stall: got %0d accesses while stalled, need 1", got_ops.size());
    else passes++;
    tx_ready = 1'b1;
    wait_idle(50, to);
    checks++; if (to) $display("FAIL backpressure_idle: busy still 1, need 0"); else passes++;
    checks++;
    if (got_tx != exp_tx || got_ops.size() != exp_ops.size()) $display("FAIL backpressure_result: got tx %p ops %0d, need tx %p ops %0d", got_tx, got_ops.size(), exp_tx, exp_ops.size());
    else passes++;
  endtask

  task automatic test_zero_len();
    logic [7:0] d[$];
    bit to;
    clear_queues();
    model_frame(8'h57, 32'h10, 0, d);
    send_frame(8'h57, 32'h10, 0, d);
    wait_idle(20, to);
    checks++;
    if (to || got_ops.size() != 0) $display("FAIL zero_len_access: got %0d accesses (timeout=%b), need 0", got_ops.size(), to);
    else passes++;
    checks++;
    if (got_tx != exp_tx) $display("FAIL zero_len_ack: got %p, need %p", got_tx, exp_tx);
    else passes++;
  endtask

  task automatic test_timeout();
    logic [7:0] d[$];
    logic [31:0] a;
    bit to;
    clear_queues();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    step(50);
    checks++;
    if (busy !== 1'b1) $display("FAIL timeout_early: busy=%b after 50 idle cycles, need 1", busy);
    else passes++;
    step(60);
    checks++;
    if (busy !== 1'b0 || got_ops.size() != 0 || got_tx.size() != 0)
      $display("FAIL timeout_abort: busy=%b ops=%0d tx=%0d, need 0/0/0", busy, got_ops.size(), got_tx.size());
    else passes++;
    a = $urandom;
    d = {8'($urandom)};
    model_frame(8'h57, a, 1, d);
    send_frame(8'h57, a, 1, d);
    wait_idle(20, to);
    checks++;
    if (to || got_ops != exp_ops || got_tx != exp_tx)
      $display("FAIL timeout_recover: ops %p tx %p, need ops %p tx %p", got_ops, got_tx, exp_ops, exp_tx);
    else passes++;
  endtask

  task automatic test_garbage_reset();
    logic [7:0] d[$];
    logic [31:0] a;
    bit to;
    clear_queues();
    send_byte(8'h41);
    step(3);
    checks++;
    if (busy !== 1'b0 || got_ops.size() != 0) $display("FAIL garbage_ignored: busy=%b ops=%0d, need 0/0", busy, got_ops.size());
    else passes++;
    a = $urandom;
    d = {8'($urandom), 8'($urandom)};
    model_frame(8'h57, a, 2, d);
    void'(exp_tx.pop_back());
    send_byte(8'h57);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    send_byte(8'h04); send_byte(8'h00);
    send_byte(d[0]); send_byte(d[1]);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr, tx_valid, tx_data} !== '0)
      $display("FAIL async_reset: busy=%b mv=%b addr=%h tv=%b tx=%h, need all 0", busy, mem_valid, mem_addr, tx_valid, tx_data);
    else passes++;
    step(2);
    rst = 1'b0;
    step(1);
    checks++;
    if (got_ops != exp_ops || got_tx.size() != 0) $display("FAIL reset_partial: ops %p tx %0d, need ops %p tx 0", got_ops, got_tx.size(), exp_ops);
    else passes++;
    clear_queues();
    a = $urandom;
    d = {8'($urandom), 8'($urandom), 8'($urandom)};
    model_frame(8'h57, a, 3, d);
    send_frame(8'h57, a, 3, d);
    model_frame(8'h52, a, 3, d);
    send_frame(8'h52, a, 3, d);
    wait_idle(50, to);
    checks++;
    if (to || got_ops != exp_ops || got_tx != exp_tx)
      $display("FAIL reset_recover: ops %p tx %p, need ops %p tx %p", got_ops, got_tx, exp_ops, exp_tx);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[$];
    logic [31:0] a;
    int len;
    bit to, any_to;
    clear_queues();
    any_to = 0;
    rand_ready = 1;
    for (int it = 0; it < 6; it++) begin
      a   = (it == 0) ? 32'hFFFF_FFFD : $urandom;
      len = $urandom_range(1, 7);
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      model_frame(8'h57, a, len, d);
      send_frame(8'h57, a, len, d);
      wait_idle(100, to); any_to |= to;
      model_frame(8'h52, a + 32'(len / 2), len - len / 2, d);
      send_frame(8'h52, a + 32'(len / 2), len - len / 2, d);
      wait_idle(200, to); any_to |= to;
    end
    rand_ready = 0;
    step(1);
    tx_ready = 1'b1;
    checks++; if (any_to) $display("FAIL b2b_idle: a frame did not finish"); else passes++;
    checks++;
    if (got_ops.size() != exp_ops.size()) $display("FAIL b2b_count: got %0d ops, need %0d", got_ops.size(), exp_ops.size());
    else passes++;
    for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++) begin
      checks++;
      if (got_ops[i] !== exp_ops[i]) $display("FAIL b2b_op%0d: got %h, need %h", i, got_ops[i], exp_ops[i]);
      else passes++;
    end
    checks++;
    if (got_tx != exp_tx) $display("FAIL b2b_tx: got %p, need %p", got_tx, exp_tx);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write_aligned();
    test_read_unaligned();
    test_backpressure();
    test_zero_len();
    test_timeout();
    test_garbage_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
